// File: rtl/ddr5_req_queue.sv
// Trace-driven DDR5 request queue: decodes addresses at enqueue, head visible one cycle after accept.
// Backpressure: in_ready drops when full or when the request's cycle is still in the future.
module ddr5_req_queue #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 34,
  parameter int NUM_CH   = 2,
  parameter int FAST_FWD = 1,
  parameter int CYC_W    = 64,
  localparam int COL_W   = (NUM_CH == 2) ? 10 : 11,
  localparam int ROW_W   = ADDR_W - 18,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CYC_W-1:0]  in_cycle,
  input  logic [3:0]        in_core,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CYC_W-1:0]  out_cycle,
  output logic [3:0]        out_core,
  output logic [1:0]        out_op,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic [1:0]        out_bank,
  output logic [2:0]        out_bg,
  output logic              out_channel,
  output logic [CNT_W-1:0]  count,
  output logic [CYC_W-1:0]  now,
  output logic              err_op
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [CYC_W-1:0] cycle;
    logic [3:0]       core;
    logic [1:0]       op;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [1:0]       bank;
    logic [2:0]       bg;
    logic             channel;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_ent;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             push;
  logic             pop;
  logic             ff_go;
  logic [CYC_W:0]   now_p1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Column takes addr[6] in place of the channel bit on single-channel parts
  always_comb begin
    wr_ent       = '0;
    wr_ent.cycle = in_cycle;
    wr_ent.core  = in_core;
    wr_ent.op    = in_op;
    wr_ent.row   = in_addr[ADDR_W-1:18];
    wr_ent.bank  = in_addr[11:10];
    wr_ent.bg    = in_addr[9:7];
    if (NUM_CH == 2) begin
      wr_ent.col     = COL_W'({in_addr[17:12], in_addr[5:2]});
      wr_ent.channel = in_addr[6];
    end else begin
      wr_ent.col     = COL_W'({in_addr[17:12], in_addr[6], in_addr[5:2]});
      wr_ent.channel = 1'b0;
    end
  end

  assign in_ready  = !reset && (count < CNT_W'(DEPTH)) && (in_cycle <= now);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (in_op != 2'd3);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // Widened so the compare stays correct when now is at all-ones
  assign now_p1 = {1'b0, now} + 1'b1;
  assign ff_go  = (FAST_FWD != 0) && (count == '0) && in_valid && ({1'b0, in_cycle} > now_p1);

  assign head        = mem[rd_ptr];
  assign out_cycle   = head.cycle;
  assign out_core    = head.core;
  assign out_op      = head.op;
  assign out_row     = head.row;
  assign out_col     = head.col;
  assign out_bank    = head.bank;
  assign out_bg      = head.bg;
  assign out_channel = head.channel;

  always_ff @(posedge clock) begin
    if (reset) begin
      now    <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err_op <= 1'b0;
    end else begin
      err_op <= accept && (in_op == 2'd3);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (ff_go)             now <= in_cycle;
      else if (now != '1)    now <= now + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

endmodule

// File: tb/tb_ddr5_req_queue.sv
// Directed bench: four queue variants share stimulus; the ones not under test are held in reset.
module tb_ddr5_req_queue;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_cycle = '0;
  logic [3:0]  in_core = '0;
  logic [1:0]  in_op = '0;
  logic [33:0] in_addr = '0;

  logic        a_in_ready, a_out_valid, a_channel, a_err_op;
  logic [63:0] a_out_cycle, a_now;
  logic [3:0]  a_out_core;
  logic [1:0]  a_out_op, a_bank;
  logic [15:0] a_row;
  logic [9:0]  a_col;
  logic [2:0]  a_bg;
  logic [4:0]  a_count;

  logic        b_in_ready, b_out_valid, b_channel, b_err_op;
  logic [63:0] b_out_cycle, b_now;
  logic [3:0]  b_out_core;
  logic [1:0]  b_out_op, b_bank;
  logic [15:0] b_row;
  logic [9:0]  b_col;
  logic [2:0]  b_bg;
  logic [4:0]  b_count;

  logic        c_in_ready, c_out_valid, c_channel, c_err_op;
  logic [63:0] c_out_cycle, c_now;
  logic [3:0]  c_out_core;
  logic [1:0]  c_out_op, c_bank;
  logic [15:0] c_row;
  logic [9:0]  c_col;
  logic [2:0]  c_bg;
  logic [2:0]  c_count;

  logic        d_in_ready, d_out_valid, d_channel, d_err_op;
  logic [63:0] d_out_cycle, d_now;
  logic [3:0]  d_out_core;
  logic [1:0]  d_out_op, d_bank;
  logic [15:0] d_row;
  logic [10:0] d_col;
  logic [2:0]  d_bg;
  logic [4:0]  d_count;

  ddr5_req_queue #(.DEPTH(16), .ADDR_W(34), .NUM_CH(2), .FAST_FWD(0), .CYC_W(64)) u_a (
    .clock(clock), .reset(rst_a), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_cycle(in_cycle), .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_cycle(a_out_cycle),
    .out_core(a_out_core), .out_op(a_out_op), .out_row(a_row), .out_col(a_col),
    .out_bank(a_bank), .out_bg(a_bg), .out_channel(a_channel), .count(a_count),
    .now(a_now), .err_op(a_err_op));

  ddr5_req_queue #(.DEPTH(16), .ADDR_W(34), .NUM_CH(2), .FAST_FWD(1), .CYC_W(64)) u_b (
    .clock(clock), .reset(rst_b), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_cycle(in_cycle), .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_cycle(b_out_cycle),
    .out_core(b_out_core), .out_op(b_out_op), .out_row(b_row), .out_col(b_col),
    .out_bank(b_bank), .out_bg(b_bg), .out_channel(b_channel), .count(b_count),
    .now(b_now), .err_op(b_err_op));

  ddr5_req_queue #(.DEPTH(5), .ADDR_W(34), .NUM_CH(2), .FAST_FWD(0), .CYC_W(64)) u_c (
    .clock(clock), .reset(rst_c), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_cycle(in_cycle), .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_cycle(c_out_cycle),
    .out_core(c_out_core), .out_op(c_out_op), .out_row(c_row), .out_col(c_col),
    .out_bank(c_bank), .out_bg(c_bg), .out_channel(c_channel), .count(c_count),
    .now(c_now), .err_op(c_err_op));

  ddr5_req_queue #(.DEPTH(16), .ADDR_W(34), .NUM_CH(1), .FAST_FWD(0), .CYC_W(64)) u_d (
    .clock(clock), .reset(rst_d), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_cycle(in_cycle), .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_cycle(d_out_cycle),
    .out_core(d_out_core), .out_op(d_out_op), .out_row(d_row), .out_col(d_col),
    .out_bank(d_bank), .out_bg(d_bg), .out_channel(d_channel), .count(d_count),
    .now(d_now), .err_op(d_err_op));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pop_idx;
    tick();
    tick();

    // Reset state of the FAST_FWD=0 instance; in_ready must stay low while reset is held
    in_valid = 1'b1;
    settle();
    check("rst_in_ready", a_in_ready, 0);
    check("rst_count", a_count, 0);
    check("rst_now", a_now, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_err_op", a_err_op, 0);

    // Request for cycle 5 waits until now reaches 5
    rst_a = 1'b0; in_cycle = 64'd5; in_core = 4'd3; in_op = 2'd0; in_addr = 34'h3_FFFF_FFC0;
    settle();
    check("early_ready", a_in_ready, 0);
    n = 0;
    while (!a_in_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_at_now", a_in_ready, 1);
    check("ready_now_val", a_now, 5);
    check("no_bypass", a_out_valid, 0);
    tick();
    in_valid = 1'b0;
    settle();
    check("dec_valid", a_out_valid, 1);
    check("dec_count", a_count, 1);
    check("dec_row", a_row, 64'hFFFF);
    check("dec_bg", a_bg, 7);
    check("dec_bank", a_bank, 3);
    check("dec_channel", a_channel, 1);
    check("dec_col", a_col, 64'h3F0);
    check("dec_cycle", a_out_cycle, 5);
    check("dec_core", a_out_core, 3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    settle();
    check("pop_count", a_count, 0);
    check("pop_valid", a_out_valid, 0);

    // Illegal op is consumed without storage and pulses err_op once
    in_valid = 1'b1; in_op = 2'd3; in_cycle = 64'd0;
    settle();
    check("ill_ready", a_in_ready, 1);
    tick();
    in_valid = 1'b0; in_op = 2'd0;
    settle();
    check("ill_err_hi", a_err_op, 1);
    check("ill_count", a_count, 0);
    tick();
    check("ill_err_lo", a_err_op, 0);
    in_valid = 1'b1; in_op = 2'd2; in_core = 4'd9; in_addr = 34'h0_0004_0000;
    tick();
    in_valid = 1'b0;
    settle();
    check("post_ill_count", a_count, 1);
    check("post_ill_op", a_out_op, 2);
    check("post_ill_core", a_out_core, 9);
    check("post_ill_row", a_row, 1);
    check("post_ill_err", a_err_op, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill to 16; pop while full must not admit the new request in the same cycle
    in_valid = 1'b1; in_op = 2'd0; in_cycle = 64'd0;
    for (int i = 0; i < 16; i++) begin
      in_core = 4'(i);
      in_addr = 34'(i) << 18;
      tick();
    end
    settle();
    check("full_count", a_count, 16);
    check("full_ready", a_in_ready, 0);
    in_core = 4'hA; out_ready = 1'b1;
    settle();
    check("full_pop_ready", a_in_ready, 0);
    tick();
    out_ready = 1'b0;
    settle();
    check("after_pop_count", a_count, 15);
    check("after_pop_ready", a_in_ready, 1);
    check("after_pop_head", a_out_core, 1);
    tick();
    in_valid = 1'b0;
    settle();
    check("refill_count", a_count, 16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("full_order", a_out_core, (i < 15) ? 64'(i + 1) : 64'hA);
      tick();
    end
    out_ready = 1'b0;
    settle();
    check("drain_count", a_count, 0);
    rst_a = 1'b1;

    // Fast-forward on an empty queue
    in_valid = 1'b0;
    tick();
    rst_b = 1'b0; in_valid = 1'b1; in_cycle = 64'd1000; in_core = 4'd5; in_op = 2'd0; in_addr = '0;
    settle();
    check("ff_ready0", b_in_ready, 0);
    check("ff_now0", b_now, 0);
    tick();
    check("ff_jump", b_now, 1000);
    check("ff_ready1", b_in_ready, 1);
    check("ff_count0", b_count, 0);
    tick();
    in_cycle = 64'd5000;
    settle();
    check("ff_count1", b_count, 1);
    check("ff_now_inc", b_now, 1001);
    check("ff_head_cycle", b_out_cycle, 1000);
    check("ff_head_core", b_out_core, 5);
    tick();
    check("ff_blocked_busy", b_now, 1002);
    in_valid = 1'b0;
    rst_b = 1'b1;

    // DEPTH=5: steady push+pop at count 3, order preserved across pointer wrap
    tick();
    rst_c = 1'b0; in_valid = 1'b1; in_cycle = 64'd0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_core = 4'(i);
      in_addr = 34'(i) << 18;
      tick();
    end
    settle();
    check("wrap_count3", c_count, 3);
    out_ready = 1'b1;
    pop_idx = 0;
    for (int i = 3; i < 12; i++) begin
      in_core = 4'(i);
      in_addr = 34'(i) << 18;
      settle();
      check("wrap_core", c_out_core, 64'(pop_idx));
      check("wrap_row", c_row, 64'(pop_idx));
      tick();
      pop_idx++;
      check("wrap_steady", c_count, 3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("wrap_tail", c_out_core, 64'(pop_idx));
      tick();
      pop_idx++;
    end
    out_ready = 1'b0;
    settle();
    check("wrap_empty", c_count, 0);
    check("wrap_empty_vld", c_out_valid, 0);
    rst_c = 1'b1;

    // NUM_CH=1 decode, then reset while holding entries
    tick();
    rst_d = 1'b0; in_valid = 1'b1; in_cycle = 64'd0; in_addr = 34'h40;
    tick();
    in_addr = 34'h80;
    tick();
    in_addr = 34'hC0;
    tick();
    in_addr = 34'h100;
    tick();
    settle();
    check("ch1_count", d_count, 4);
    check("ch1_col", d_col, 64'h010);
    check("ch1_channel", d_channel, 0);
    rst_d = 1'b1;
    settle();
    check("ch1_rst_ready", d_in_ready, 0);
    tick();
    in_valid = 1'b0;
    check("ch1_rst_count", d_count, 0);
    check("ch1_rst_valid", d_out_valid, 0);
    check("ch1_rst_now", d_now, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
